// File: rtl/neuro_pkg.sv
// Shared neuron definitions: default widths, FSM states and saturation helpers.
// The helpers work on 32-bit containers so that parameterised callers can size-cast the result.
package neuro_pkg;

  localparam int N_IN_DEF  = 2;
  localparam int DW_DEF    = 4;
  localparam int ACCW_DEF  = 12;
  localparam int SHIFT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    ACT  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Unsigned add clamped to the largest w-bit value.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

  // Clamp an unsigned value to the largest w-bit value.
  function automatic logic [31:0] sat_to_w(input logic [31:0] v, input int unsigned w);
    logic [32:0] lim;
    lim = (33'd1 << w) - 33'd1;
    return ({1'b0, v} > lim) ? lim[31:0] : v;
  endfunction

endpackage

// File: rtl/output_neuron_if.sv
// Activation-in / result-out valid-ready streams of the neuron.
// master drives samples and out_ready; slave is the neuron itself.
interface output_neuron_if #(
  parameter int DW = neuro_pkg::DW_DEF
) ();
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] outf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, outf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, outf
  );
endinterface

// File: rtl/neuro_mac_sat.sv
// Combinational multiply-accumulate: acc_o = sat(acc_i + a_i*w_i) at ACCW bits.
// Purely combinational, no flow control; the caller decides when to register acc_o.
module neuro_mac_sat
  import neuro_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int ACCW = ACCW_DEF
) (
  input  logic [DW-1:0]   a_i,
  input  logic [DW-1:0]   w_i,
  input  logic [ACCW-1:0] acc_i,
  output logic [ACCW-1:0] acc_o
);

  logic [2*DW-1:0] prod;

  assign prod  = a_i * w_i;
  assign acc_o = ACCW'(sat_add(32'(prod), 32'(acc_i), ACCW));

endmodule

// File: rtl/output_neuron.sv
// Weighted sum of N_IN activations, shifted and thresholded into one DW-bit result (NEURON_BIAS_EN adds a bias).
// Result valid 1 cycle after the last accept; in_ready stays low until the held result is taken by out_ready.
module output_neuron
  import neuro_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int DW    = DW_DEF,
  parameter int ACCW  = ACCW_DEF,
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            w_we,
  input  logic [3:0]      w_addr,
  input  logic [DW-1:0]   w_data,
  input  logic [DW-1:0]   T,
  output logic            busy,
  output_neuron_if.slave  io
);

  state_t          state_q;
  logic [ACCW-1:0] acc_q;
  logic [ACCW-1:0] acc_d;
  logic [ACCW-1:0] base;
  logic [ACCW-1:0] net;
  logic [3:0]      idx_q;
  logic [DW-1:0]   w_q [N_IN];
  logic [DW-1:0]   w_cur;
  logic [DW-1:0]   outf_q;
  logic [DW-1:0]   outf_d;
  logic            out_valid_q;
  logic            accept;
  logic            last;

`ifdef NEURON_BIAS_EN
  logic [DW-1:0]   bias_q;
  logic [ACCW-1:0] bias_acc;

  assign bias_acc = ACCW'(sat_to_w(32'(bias_q) << SHIFT, ACCW));
`endif

  assign io.in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign io.out_valid = out_valid_q;
  assign io.outf      = outf_q;
  assign busy         = (state_q != IDLE);

  assign accept = io.in_valid & io.in_ready;
  assign last   = (idx_q == 4'(N_IN - 1));

  always_comb begin
    w_cur = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (idx_q == 4'(i)) w_cur = w_q[i];
    end
  end

  // The first sample of a set starts from the bias (or zero), never from a stale sum.
  always_comb begin
`ifdef NEURON_BIAS_EN
    base = (state_q == IDLE) ? bias_acc : acc_q;
`else
    base = (state_q == IDLE) ? '0 : acc_q;
`endif
  end

  neuro_mac_sat #(
    .DW   (DW),
    .ACCW (ACCW)
  ) u_mac (
    .a_i   (io.in_data),
    .w_i   (w_cur),
    .acc_i (base),
    .acc_o (acc_d)
  );

  assign net    = acc_q >> SHIFT;
  assign outf_d = (net >= ACCW'(T)) ? DW'(sat_to_w(32'(net), DW)) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      outf_q      <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < N_IN; i++) w_q[i] <= '0;
`ifdef NEURON_BIAS_EN
      bias_q      <= '0;
`endif
    end else begin
      // Weights only change between sample sets; the MAC reads the old value this cycle.
      if ((state_q == IDLE) && w_we) begin
        for (int i = 0; i < N_IN; i++) begin
          if (w_addr == 4'(i)) w_q[i] <= w_data;
        end
`ifdef NEURON_BIAS_EN
        if (w_addr == 4'(N_IN)) bias_q <= w_data;
`endif
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q   <= acc_d;
            idx_q   <= 4'd1;
            state_q <= (N_IN == 1) ? ACT : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc_q <= acc_d;
            idx_q <= idx_q + 4'd1;
            if (last) state_q <= ACT;
          end
        end
        ACT: begin
          outf_q      <= outf_d;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_neuron.sv
// Bench for output_neuron: directed table, hand-written corner sequences, then randomized sets
// checked against an arithmetic model of the weighted sum, shift, threshold and clamp.
module tb_output_neuron;

  logic       clk    = 1'b0;
  logic       reset  = 1'b0;
  logic       w_we   = 1'b0;
  logic [3:0] w_addr = 4'd0;
  logic [3:0] w_data = 4'd0;
  logic [3:0] T      = 4'd0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int w_m[2];
  int bias_m;
  int bias_exp;

  typedef struct {
    int w0;
    int w1;
    int d0;
    int d1;
    int t;
    int exp;
  } vec_t;

  vec_t tbl[10];

  output_neuron_if #(.DW(4)) io ();

  output_neuron #(
    .N_IN  (2),
    .DW    (4),
    .ACCW  (12),
    .SHIFT (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .w_we   (w_we),
    .w_addr (w_addr),
    .w_data (w_data),
    .T      (T),
    .busy   (busy),
    .io     (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: sum of bias<<4 and products, clamp at 4095, >>4, threshold, clamp to 15.
  function automatic int model(input int d0, input int d1, input int t);
    int s;
    int net;
    s = bias_m * 16 + d0 * w_m[0] + d1 * w_m[1];
    if (s > 4095) s = 4095;
    net = s / 16;
    if (net < t) return 0;
    return (net > 15) ? 15 : net;
  endfunction

  task automatic wr(input int a, input int d);
    @(posedge clk); #1;
    w_we = 1'b1; w_addr = 4'(a); w_data = 4'(d);
    @(posedge clk); #1;
    w_we = 1'b0;
    if (a < 2) w_m[a] = d;
`ifdef NEURON_BIAS_EN
    if (a == 2) bias_m = d;
`endif
  endtask

  task automatic send(input int d, input int gap);
    int n = 0;
    io.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    io.in_valid = 1'b1;
    io.in_data  = 4'(d);
    while (!io.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) chk("send timeout", n, 0);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic get(input int exp, input int hold, input string name);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!io.out_valid && n < 50);
    chk({name, " latency"}, n, 1);
    chk({name, " outf"}, io.outf, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({name, " hold"}, {io.out_valid, io.in_ready, busy, io.outf}, {3'b101, 4'(exp)});
    end
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    io.out_ready = 1'b0;
    chk({name, " release"}, {io.out_valid, io.in_ready, busy}, 3'b010);
  endtask

  task automatic run_set(input int d0, input int d1, input int t, input int exp,
                         input int gap, input int hold, input string name);
    T = 4'(t);
    send(d0, 0);
    send(d1, gap);
    get(exp, hold, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    io.in_valid  = 1'b0;
    io.in_data   = 4'd0;
    io.out_ready = 1'b0;
    w_m          = '{0, 0};
    bias_m       = 0;
`ifdef NEURON_BIAS_EN
    bias_exp = 9;
`else
    bias_exp = 6;
`endif

    tbl[0] = '{15, 13, 14,  6,  0, 15};
    tbl[1] = '{15,  5, 11,  3,  0, 11};
    tbl[2] = '{15,  5, 11,  3, 12,  0};
    tbl[3] = '{15,  5,  7,  1,  0,  6};
    tbl[4] = '{15,  5, 11,  3, 11, 11};
    tbl[5] = '{ 0,  0,  5,  5,  0,  0};
    tbl[6] = '{15, 15, 15, 15,  0, 15};
    tbl[7] = '{ 1,  1,  1,  1,  0,  0};
    tbl[8] = '{15, 15, 15, 15, 15, 15};
    tbl[9] = '{ 8,  0,  2,  9,  1,  1};

    #12;
    chk("reset state", {io.out_valid, busy, io.outf}, 6'd0);
    #5 reset = 1'b1;
    #1 chk("in_ready after reset", io.in_ready, 1);
    @(posedge clk); #1;

    for (int k = 0; k < 10; k++) begin
      wr(0, tbl[k].w0);
      wr(1, tbl[k].w1);
      run_set(tbl[k].d0, tbl[k].d1, tbl[k].t, tbl[k].exp, 0, 0, $sformatf("table%0d", k));
    end

    // Result held for 5 cycles with out_ready low.
    wr(0, 15);
    wr(1, 5);
    run_set(11, 3, 0, 11, 0, 5, "hold");

    // Input gap in ACC with a weight write that must be ignored.
    T = 4'd0;
    send(11, 0);
    w_we = 1'b1; w_addr = 4'd0; w_data = 4'd2;
    @(posedge clk); #1;
    w_we = 1'b0;
    chk("gap state", {busy, io.in_ready, io.out_valid}, 3'b110);
    @(posedge clk); #1;
    send(3, 0);
    get(11, 0, "gap");
    run_set(11, 3, 0, 11, 0, 0, "gap weight kept");

    // Weight write coinciding with the first accept: old weight used, new weight stored.
    T = 4'd0;
    io.in_valid = 1'b1; io.in_data = 4'd11;
    w_we = 1'b1; w_addr = 4'd0; w_data = 4'd1;
    @(posedge clk); #1;
    io.in_valid = 1'b0; w_we = 1'b0;
    w_m[0] = 1;
    send(3, 0);
    get(11, 0, "same-cycle old weight");
    run_set(11, 3, 0, 1, 0, 0, "same-cycle new weight");

    // Reset in the middle of a set discards the partial sum and the weights.
    wr(0, 9);
    wr(1, 9);
    T = 4'd0;
    send(9, 0);
    chk("busy before abort", busy, 1);
    reset = 1'b0;
    #1 chk("reset mid-set", {busy, io.out_valid, io.outf}, 6'd0);
    #3 reset = 1'b1;
    #1 chk("in_ready after abort", io.in_ready, 1);
    w_m    = '{0, 0};
    bias_m = 0;
    @(posedge clk); #1;
    run_set(7, 1, 0, 0, 0, 0, "weights cleared");
    wr(0, 15);
    wr(1, 5);
    run_set(7, 1, 0, 6, 0, 0, "after reset");

    // Bias register at address N_IN (ignored when the bias option is absent).
    wr(2, 3);
    run_set(7, 1, 0, bias_exp, 0, 0, "bias");

    for (int k = 0; k < 60; k++) begin
      int d0;
      int d1;
      int t;
      if ($urandom % 2 == 1) wr(int'($urandom % 6), int'($urandom % 16));
      d0 = int'($urandom % 16);
      d1 = int'($urandom % 16);
      t  = ($urandom % 3 == 0) ? int'($urandom % 16) : int'($urandom % 3);
      run_set(d0, d1, t, model(d0, d1, t), int'($urandom % 3), int'($urandom % 3), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
